// File: rtl/axi_mem_resp_pkg.sv
// Shared types and constants for the BRAM-backed AXI4 responder.
//   AXI_RESP_*   : response codes driven on rresp/bresp
//   BEAT_BYTES   : bytes per 512-bit beat
//   b_entry_t    : one pending write response {id, resp}
//   w_state_t / r_state_t : write and read FSM encodings
package axi_mem_resp_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam int         BEAT_BYTES      = 64;
   localparam logic [2:0] AXI_SIZE_64B    = 3'b110;

   typedef struct packed {
      logic [15:0] id;
      logic [1:0]  resp;
   } b_entry_t;

   typedef enum logic {W_IDLE, W_DATA} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   function automatic logic [1:0] resp_of(input logic err);
      return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_mem_resp_if.sv
// 512-bit AXI4 bus (AR/AW/W/R/B) between the DMA initiator and the memory
// responder. The "master" modport is the responder end (it owns the ready,
// R and B signals); "slave" is the initiator end.
interface axi_bus_t;
   logic [63:0]  araddr;
   logic [15:0]  arid;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic         arvalid;
   logic         arready;
   logic [63:0]  awaddr;
   logic [15:0]  awid;
   logic [7:0]   awlen;
   logic [2:0]   awsize;
   logic         awvalid;
   logic         awready;
   logic [511:0] wdata;
   logic [63:0]  wstrb;
   logic         wlast;
   logic         wvalid;
   logic         wready;
   logic [15:0]  rid;
   logic [511:0] rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;
   logic [15:0]  bid;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready;

   modport master (
      input  araddr, arid, arlen, arsize, arvalid,
      input  awaddr, awid, awlen, awsize, awvalid,
      input  wdata, wstrb, wlast, wvalid,
      input  rready, bready,
      output arready, awready, wready,
      output rid, rdata, rresp, rlast, rvalid,
      output bid, bresp, bvalid
   );

   modport slave (
      output araddr, arid, arlen, arsize, arvalid,
      output awaddr, awid, awlen, awsize, awvalid,
      output wdata, wstrb, wlast, wvalid,
      output rready, bready,
      input  arready, awready, wready,
      input  rid, rdata, rresp, rlast, rvalid,
      input  bid, bresp, bvalid
   );
endinterface

// File: rtl/axi_mem_resp_rpipe.sv
// Read issue engine plus 2-entry output skid buffer.
//   i_start/i_idx/i_len : burst start (AR handshake), first word, beats-1
//   o_idle              : engine idle and nothing in flight or buffered
//   o_rd_en/o_rd_idx    : BRAM read port request (data returns next cycle)
//   i_rd_data           : BRAM read data register
//   o_valid/o_data/o_last/i_ready : beat output towards R
//
// state  | meaning
// R_IDLE | no burst being issued
// R_DATA | issuing one BRAM read per cycle while the buffer has room
module axi_mem_resp_rpipe
   import axi_mem_resp_pkg::*;
#(
   parameter int LOG_WORDS = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_start,
   input  logic [LOG_WORDS-1:0] i_idx,
   input  logic [7:0]           i_len,
   output logic                 o_idle,
   output logic                 o_rd_en,
   output logic [LOG_WORDS-1:0] o_rd_idx,
   input  logic [511:0]         i_rd_data,
   output logic                 o_valid,
   output logic [511:0]         o_data,
   output logic                 o_last,
   input  logic                 i_ready
);

   r_state_t             r_state, w_state_nxt;
   logic [LOG_WORDS-1:0] r_idx, w_idx_nxt;
   logic [7:0]           r_left, w_left_nxt;
   logic                 r_rd_v, r_rd_last, w_issue_last;
   logic [511:0]         r_q_data [0:1];
   logic                 r_q_last [0:1];
   logic                 r_wp, r_rp;
   logic [1:0]           r_cnt;
   logic                 w_pop;
   logic [2:0]           w_occ;
   logic                 w_room;

   assign o_valid = (r_cnt != 2'd0);
   assign o_data  = r_q_data[r_rp];
   assign o_last  = r_q_last[r_rp];
   assign w_pop   = o_valid && i_ready;
   // A read issued now lands in the buffer two edges later, so count the
   // BRAM register as occupied and credit the beat leaving this cycle.
   assign w_occ   = {1'b0, r_cnt} + {2'b00, r_rd_v} - {2'b00, w_pop};
   assign w_room  = (w_occ < 3'd2);
   assign o_idle  = (r_state == R_IDLE) && (r_cnt == 2'd0) && !r_rd_v;
   assign o_rd_idx = r_idx;

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_left_nxt   = r_left;
      o_rd_en      = 1'b0;
      w_issue_last = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (i_start) begin
               w_state_nxt = R_DATA;
               w_idx_nxt   = i_idx;
               w_left_nxt  = i_len;
            end
         end
         R_DATA: begin
            if (w_room) begin
               o_rd_en   = 1'b1;
               w_idx_nxt = r_idx + LOG_WORDS'(1);
               if (r_left == 8'd0) begin
                  w_issue_last = 1'b1;
                  w_state_nxt  = R_IDLE;
               end else begin
                  w_left_nxt = r_left - 8'd1;
               end
            end
         end
         default: w_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= R_IDLE;
         r_idx     <= '0;
         r_left    <= '0;
         r_rd_v    <= 1'b0;
         r_rd_last <= 1'b0;
         r_wp      <= 1'b0;
         r_rp      <= 1'b0;
         r_cnt     <= 2'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_idx     <= w_idx_nxt;
         r_left    <= w_left_nxt;
         r_rd_v    <= o_rd_en;
         r_rd_last <= w_issue_last;
         if (r_rd_v) r_wp <= ~r_wp;
         if (w_pop)  r_rp <= ~r_rp;
         r_cnt <= r_cnt + {1'b0, r_rd_v} - {1'b0, w_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (r_rd_v) begin
         r_q_data[r_wp] <= i_rd_data;
         r_q_last[r_wp] <= r_rd_last;
      end
   end

endmodule

// File: rtl/axi_mem_resp.sv
// BRAM-backed AXI4 responder for the 512-bit DMA bus.
//   clk, rst      : clock, synchronous active-high reset
//   axi           : responder end of the AXI4 bus
//   o_wr_bursts   : completed write bursts (B handshakes)
//   o_rd_bursts   : completed read bursts (rlast handshakes)
//   o_err_bursts  : bursts completed with SLVERR
//
// state  | meaning
// W_IDLE | waiting for AW (blocked while the B queue is full)
// W_DATA | accepting W beats until wlast
module axi_mem_resp
   import axi_mem_resp_pkg::*;
#(
   parameter int LOG_WORDS = 10,
   parameter int B_LD      = 2
) (
   input  logic        clk,
   input  logic        rst,
   axi_bus_t.master    axi,
   output logic [31:0] o_wr_bursts,
   output logic [31:0] o_rd_bursts,
   output logic [31:0] o_err_bursts
);

   logic [511:0]         r_mem [0:(1<<LOG_WORDS)-1];
   logic [511:0]         r_rd_data;
   logic                 w_rd_en;
   logic [LOG_WORDS-1:0] w_rd_idx;

   // ---------------- read side ----------------
   logic        w_r_idle, w_ar_hs, w_rvalid, w_rlast, w_rd_done;
   logic [511:0] w_rdata;
   logic [15:0] r_rid;
   logic        r_rerr;

   assign axi.arready = !rst && w_r_idle;
   assign w_ar_hs     = axi.arvalid && axi.arready;

   always_ff @(posedge clk) begin
      if (w_ar_hs) begin
         r_rid  <= axi.arid;
         r_rerr <= (axi.arsize != AXI_SIZE_64B);
      end
   end

   axi_mem_resp_rpipe #(.LOG_WORDS(LOG_WORDS)) u_rpipe (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_ar_hs),
      .i_idx     (axi.araddr[6 +: LOG_WORDS]),
      .i_len     (axi.arlen),
      .o_idle    (w_r_idle),
      .o_rd_en   (w_rd_en),
      .o_rd_idx  (w_rd_idx),
      .i_rd_data (r_rd_data),
      .o_valid   (w_rvalid),
      .o_data    (w_rdata),
      .o_last    (w_rlast),
      .i_ready   (axi.rready)
   );

   assign axi.rvalid = w_rvalid;
   assign axi.rdata  = w_rdata;
   assign axi.rlast  = w_rlast;
   assign axi.rid    = r_rid;
   assign axi.rresp  = resp_of(r_rerr);
   assign w_rd_done  = w_rvalid && axi.rready && w_rlast;

   // ---------------- write side ----------------
   w_state_t             r_wstate, w_wstate_nxt;
   logic [15:0]          r_wid;
   logic [LOG_WORDS-1:0] r_widx;
   logic [8:0]           r_wleft;
   logic                 r_werr, w_werr_now;
   logic                 w_awready, w_wready, w_aw_hs, w_w_hs, w_we, w_bpush;

   b_entry_t             r_bq [0:(1<<B_LD)-1];
   logic [B_LD-1:0]      r_bwp, r_brp;
   logic [B_LD:0]        r_bcnt;
   logic                 w_bfull, w_bpop;

   // Count reaches exactly 2^B_LD only when full, so its MSB is the full flag.
   assign w_bfull = r_bcnt[B_LD];

   // Beats past awlen+1 and an early wlast both poison the burst.
   assign w_werr_now = r_werr || (r_wleft == 9'd0) || (axi.wlast && (r_wleft != 9'd1));

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_awready    = 1'b0;
      w_wready     = 1'b0;
      w_we         = 1'b0;
      w_bpush      = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            w_awready = !rst && !w_bfull;
            if (axi.awvalid && w_awready) w_wstate_nxt = W_DATA;
         end
         W_DATA: begin
            w_wready = !rst;
            if (axi.wvalid && w_wready) begin
               w_we = (r_wleft != 9'd0);
               if (axi.wlast) begin
                  w_bpush      = 1'b1;
                  w_wstate_nxt = W_IDLE;
               end
            end
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   assign axi.awready = w_awready;
   assign axi.wready  = w_wready;
   assign w_aw_hs     = axi.awvalid && w_awready;
   assign w_w_hs      = axi.wvalid && w_wready;

   always_ff @(posedge clk) begin
      if (rst) r_wstate <= W_IDLE;
      else     r_wstate <= w_wstate_nxt;
   end

   always_ff @(posedge clk) begin
      if (w_aw_hs) begin
         r_wid   <= axi.awid;
         r_widx  <= axi.awaddr[6 +: LOG_WORDS];
         r_wleft <= {1'b0, axi.awlen} + 9'd1;
         r_werr  <= (axi.awsize != AXI_SIZE_64B);
      end else if (w_w_hs) begin
         r_werr <= w_werr_now;
         if (w_we) begin
            r_widx  <= r_widx + LOG_WORDS'(1);
            r_wleft <= r_wleft - 9'd1;
         end
      end
   end

   // Dual-port memory; the read port samples before the write lands (read-first).
   always_ff @(posedge clk) begin
      if (w_rd_en) r_rd_data <= r_mem[w_rd_idx];
   end

   always_ff @(posedge clk) begin
      if (w_we) begin
         for (int b = 0; b < BEAT_BYTES; b++) begin
            if (axi.wstrb[b]) r_mem[r_widx][b*8 +: 8] <= axi.wdata[b*8 +: 8];
         end
      end
   end

   // ---------------- B queue ----------------
   assign axi.bvalid = (r_bcnt != '0);
   assign axi.bid    = r_bq[r_brp].id;
   assign axi.bresp  = r_bq[r_brp].resp;
   assign w_bpop     = axi.bvalid && axi.bready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bwp  <= '0;
         r_brp  <= '0;
         r_bcnt <= '0;
      end else begin
         if (w_bpush) begin
            r_bq[r_bwp] <= '{id: r_wid, resp: resp_of(w_werr_now)};
            r_bwp       <= r_bwp + (B_LD)'(1);
         end
         if (w_bpop) r_brp <= r_brp + (B_LD)'(1);
         r_bcnt <= r_bcnt + (B_LD+1)'(w_bpush) - (B_LD+1)'(w_bpop);
      end
   end

   // ---------------- statistics ----------------
   logic w_b_err, w_r_err;
   assign w_b_err = w_bpop && (axi.bresp == AXI_RESP_SLVERR);
   assign w_r_err = w_rd_done && r_rerr;

   always_ff @(posedge clk) begin
      if (rst) begin
         o_wr_bursts  <= '0;
         o_rd_bursts  <= '0;
         o_err_bursts <= '0;
      end else begin
         o_wr_bursts  <= o_wr_bursts + 32'(w_bpop);
         o_rd_bursts  <= o_rd_bursts + 32'(w_rd_done);
         o_err_bursts <= o_err_bursts + 32'(w_b_err) + 32'(w_r_err);
      end
   end

   // Address bits outside the word index alias away.
   logic w_unused_addr;
   assign w_unused_addr = ^{axi.araddr[63:6+LOG_WORDS], axi.araddr[5:0],
                            axi.awaddr[63:6+LOG_WORDS], axi.awaddr[5:0]};

endmodule
